// File: rtl/alu_issue_ctrl.sv
// Issue controller for an external combinational/latency-fixed 8-bit ALU: accepts instruction
// words, reads a 4-entry register file, drives the ALU, captures and writes back its result.
module alu_issue_ctrl #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ins_valid,
  output logic             ins_ready,
  input  logic [7:0]       ins_data,
  input  logic             ld_en,
  input  logic [1:0]       ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  output logic [1:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [1:0]       res_rd,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_cnt, w_cnt_nxt;
  logic             r_ins_ready;
  logic [1:0]       r_alu_op;
  logic [WIDTH-1:0] r_alu_a, r_alu_b, r_res_data;
  logic [1:0]       r_res_rd;
  logic [WIDTH-1:0] r_rf [4];
  logic             w_accept, w_wb;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_wb        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (ins_valid && r_ins_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = EXEC;
          w_cnt_nxt   = 4'(ALU_LAT - 1);
        end
      end
      EXEC: begin
        if (r_cnt == 4'd0) begin
          w_wb        = 1'b1;
          w_state_nxt = RESP;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      RESP: begin
        if (res_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_ins_ready <= 1'b0;
      r_alu_op    <= 2'd0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_res_data  <= '0;
      r_res_rd    <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ins_ready <= (w_state_nxt == IDLE);
      if (w_accept) begin
        // Operands come from the register file as it stood before this edge's writes.
        r_alu_op <= ins_data[7:6];
        r_alu_a  <= r_rf[ins_data[3:2]];
        r_alu_b  <= r_rf[ins_data[1:0]];
        r_res_rd <= ins_data[5:4];
      end
      if (w_wb) r_res_data <= alu_result;
    end
  end

  // The writeback assignment comes last so it wins over a same-address load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_rf[i] <= '0;
    end else begin
      if (ld_en) r_rf[ld_addr] <= ld_data;
      if (w_wb) r_rf[r_res_rd] <= alu_result;
    end
  end

  assign ins_ready = r_ins_ready;
  assign alu_op    = r_alu_op;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign res_valid = (r_state == RESP);
  assign res_data  = r_res_data;
  assign res_rd    = r_res_rd;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: one instance with ALU_LAT=1 and one with ALU_LAT=4, each driven
// by a behavioural ALU, checked against a register-file/result model.
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  always #5 clk = ~clk;

  // ALU_LAT = 1 instance
  logic       ins_valid = 1'b0, ins_ready;
  logic [7:0] ins_data = 8'h00;
  logic       ld_en = 1'b0;
  logic [1:0] ld_addr = 2'd0;
  logic [7:0] ld_data = 8'h00;
  logic [1:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_result;
  logic       res_valid, res_ready = 1'b0;
  logic [7:0] res_data;
  logic [1:0] res_rd;
  logic       busy;

  // ALU_LAT = 4 instance
  logic       ins_valid_4 = 1'b0, ins_ready_4;
  logic [7:0] ins_data_4 = 8'h00;
  logic       ld_en_4 = 1'b0;
  logic [1:0] ld_addr_4 = 2'd0;
  logic [7:0] ld_data_4 = 8'h00;
  logic [1:0] alu_op_4;
  logic [7:0] alu_a_4, alu_b_4, alu_result_4;
  logic       res_valid_4, res_ready_4 = 1'b0;
  logic [7:0] res_data_4;
  logic [1:0] res_rd_4;
  logic       busy_4;

  alu_issue_ctrl #(.WIDTH(8), .ALU_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .ins_data(ins_data), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_rd(res_rd),
    .busy(busy)
  );

  alu_issue_ctrl #(.WIDTH(8), .ALU_LAT(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .ins_valid(ins_valid_4), .ins_ready(ins_ready_4),
    .ins_data(ins_data_4), .ld_en(ld_en_4), .ld_addr(ld_addr_4), .ld_data(ld_data_4),
    .alu_op(alu_op_4), .alu_a(alu_a_4), .alu_b(alu_b_4), .alu_result(alu_result_4),
    .res_valid(res_valid_4), .res_ready(res_ready_4), .res_data(res_data_4),
    .res_rd(res_rd_4), .busy(busy_4)
  );

  function automatic logic [7:0] alu_f(input logic [1:0] op, input logic [7:0] a,
                                       input logic [7:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return ~a;
      2'b10:   return a ^ b;
      default: return a | b;
    endcase
  endfunction

  // cyc changes on falling edges only, so it is stable whenever the DUT samples.
  int cyc = 0;
  always @(negedge clk) cyc <= cyc + 1;

  assign alu_result   = alu_f(alu_op, alu_a, alu_b);
  assign alu_result_4 = alu_f(alu_op_4, alu_a_4, alu_b_4) ^ cyc[7:0];

  logic [7:0] rf_m [4];
  logic [7:0] rf4_m [4];
  int n_cmp = 0;
  int n_fail = 0;
  int acc_prev = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ld(input logic [1:0] addr, input logic [7:0] data);
    ld_en = 1'b1; ld_addr = addr; ld_data = data;
    @(negedge clk);
    ld_en = 1'b0;
    rf_m[addr] = data;
  endtask

  // Starts and ends just after a falling edge with the ALU_LAT=1 instance idle.
  task automatic do_op(input logic [7:0] ins, input int hold, input bit chk_iv,
                       input bit al_en, input logic [1:0] al_addr, input logic [7:0] al_data,
                       input bit wl_en, input logic [1:0] wl_addr, input logic [7:0] wl_data);
    logic [1:0] op, rd;
    logic [7:0] ea, eb, er;
    op = ins[7:6]; rd = ins[5:4];
    ea = rf_m[ins[3:2]]; eb = rf_m[ins[1:0]];
    er = alu_f(op, ea, eb);
    chk("idle_ins_ready", 32'(ins_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    ins_valid = 1'b1; ins_data = ins; res_ready = 1'b0;
    ld_en = al_en; ld_addr = al_addr; ld_data = al_data;
    @(posedge clk);
    if (chk_iv) chk("issue_interval", 32'(cyc - acc_prev), 32'd3);
    acc_prev = cyc;
    if (al_en) rf_m[al_addr] = al_data;
    @(negedge clk);
    ins_valid = 1'($urandom_range(0, 1)); ins_data = 8'($urandom);
    res_ready = 1'($urandom_range(0, 1));
    ld_en = wl_en; ld_addr = wl_addr; ld_data = wl_data;
    chk("exec_alu_op", 32'(alu_op), 32'(op));
    chk("exec_alu_a", 32'(alu_a), 32'(ea));
    chk("exec_alu_b", 32'(alu_b), 32'(eb));
    chk("exec_ins_ready", 32'(ins_ready), 32'd0);
    chk("exec_busy", 32'(busy), 32'd1);
    chk("exec_res_valid", 32'(res_valid), 32'd0);
    @(posedge clk);
    if (wl_en) rf_m[wl_addr] = wl_data;
    rf_m[rd] = er;
    @(negedge clk);
    ld_en = 1'b0; res_ready = 1'b0;
    chk("resp_valid", 32'(res_valid), 32'd1);
    chk("resp_data", 32'(res_data), 32'(er));
    chk("resp_rd", 32'(res_rd), 32'(rd));
    chk("resp_ins_ready", 32'(ins_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      ins_valid = 1'($urandom_range(0, 1)); ins_data = 8'($urandom);
      @(negedge clk);
      chk("hold_valid", 32'(res_valid), 32'd1);
      chk("hold_data", 32'(res_data), 32'(er));
      chk("hold_rd", 32'(res_rd), 32'(rd));
      chk("hold_ins_ready", 32'(ins_ready), 32'd0);
    end
    ins_valid = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("done_res_valid", 32'(res_valid), 32'd0);
    chk("done_ins_ready", 32'(ins_ready), 32'd1);
    chk("done_alu_a_kept", 32'(alu_a), 32'(ea));
  endtask

  task automatic do_op4(input logic [7:0] ins);
    logic [7:0] ea, eb, er;
    int c;
    ea = rf4_m[ins[3:2]]; eb = rf4_m[ins[1:0]];
    chk("l4_ins_ready", 32'(ins_ready_4), 32'd1);
    ins_valid_4 = 1'b1; ins_data_4 = ins; res_ready_4 = 1'b0;
    @(posedge clk);
    c = cyc;
    @(negedge clk);
    ins_valid_4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("l4_exec_res_valid", 32'(res_valid_4), 32'd0);
      chk("l4_exec_busy", 32'(busy_4), 32'd1);
      @(negedge clk);
    end
    chk("l4_exec4_res_valid", 32'(res_valid_4), 32'd0);
    chk("l4_alu_a", 32'(alu_a_4), 32'(ea));
    chk("l4_alu_b", 32'(alu_b_4), 32'(eb));
    er = alu_f(ins[7:6], ea, eb) ^ 8'(c + 4);
    @(negedge clk);
    chk("l4_res_valid", 32'(res_valid_4), 32'd1);
    chk("l4_res_data", 32'(res_data_4), 32'(er));
    chk("l4_res_rd", 32'(res_rd_4), 32'(ins[5:4]));
    rf4_m[ins[5:4]] = er;
    res_ready_4 = 1'b1;
    @(negedge clk);
    res_ready_4 = 1'b0;
    chk("l4_done_valid", 32'(res_valid_4), 32'd0);
    chk("l4_done_ready", 32'(ins_ready_4), 32'd1);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ins_ready", 32'(ins_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_res_rd", 32'(res_rd), 32'd0);
    chk("rst_ins_ready_4", 32'(ins_ready_4), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin rf_m[i] = 8'h00; rf4_m[i] = 8'h00; end
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ins_ready", 32'(ins_ready), 32'd1);

    ld(2'd0, 8'hF0);
    ld(2'd1, 8'h3C);
    do_op(8'h21, 0, 0, 0, 2'd0, 8'h00, 0, 2'd0, 8'h00);
    do_op(8'h70, 0, 1, 0, 2'd0, 8'h00, 0, 2'd0, 8'h00);
    do_op(8'hA1, 0, 1, 0, 2'd0, 8'h00, 0, 2'd0, 8'h00);
    do_op(8'hE1, 0, 1, 0, 2'd0, 8'h00, 0, 2'd0, 8'h00);
    do_op(8'hC4, 5, 0, 0, 2'd0, 8'h00, 0, 2'd0, 8'h00);

    // Load/writeback collision on r2, then read r2 back through an operand.
    ld(2'd0, 8'hF0);
    ld(2'd1, 8'h3C);
    do_op(8'h21, 0, 0, 0, 2'd0, 8'h00, 1, 2'd2, 8'h55);
    do_op(8'hFA, 0, 0, 0, 2'd0, 8'h00, 0, 2'd0, 8'h00);
    // Load to rs1 on the acceptance edge: old operand used, new value visible later.
    do_op(8'h21, 0, 0, 1, 2'd0, 8'h11, 0, 2'd0, 8'h00);
    do_op(8'hF0, 0, 0, 0, 2'd0, 8'h00, 0, 2'd0, 8'h00);

    for (int n = 0; n < 40; n++) begin
      do_op(8'($urandom), $urandom_range(0, 2), 0,
            1'($urandom_range(0, 1)), 2'($urandom), 8'($urandom),
            1'($urandom_range(0, 1)), 2'($urandom), 8'($urandom));
    end

    do_op4(8'h40);
    do_op4(8'h64);
    do_op4(8'hB9);
    do_op4(8'hDE);

    // Reset in the middle of an ALU_LAT=1 operation.
    ins_valid = 1'b1; ins_data = 8'hE1;
    @(posedge clk);
    @(negedge clk);
    ins_valid = 1'b0;
    chk("pre_abort_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1 chk_reset_outputs();
    for (int i = 0; i < 4; i++) begin rf_m[i] = 8'h00; rf4_m[i] = 8'h00; end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ins_ready", 32'(ins_ready), 32'd1);
    chk("abort_res_valid", 32'(res_valid), 32'd0);
    @(negedge clk);
    chk("abort_res_valid_late", 32'(res_valid), 32'd0);
    do_op(8'hE1, 0, 0, 0, 2'd0, 8'h00, 0, 2'd0, 8'h00);
    do_op(8'h4B, 0, 0, 0, 2'd0, 8'h00, 0, 2'd0, 8'h00);
    do_op(8'h8F, 0, 0, 0, 2'd0, 8'h00, 0, 2'd0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
